// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose: common FSM encoding, FIFO entry layout, datapath width and the
// default reset PC used by instr_fetch_unit and fetch_fifo2.
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    REQ  = 2'd1,  // request outstanding, response will be buffered
    DROP = 2'd2   // request outstanding, response belongs to a squashed path
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Clear the byte offset so redirects always land on a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo2.sv
// rtl/instr_fetch_unit_fifo2.sv - two-entry {instr, pc} buffer between memory and decode
//
// Purpose: holds up to two fetched instructions so fetch can run ahead of a
// stalled decode stage.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   push      - write din at the tail this cycle
//   pop       - remove the head entry this cycle
//   flush     - discard all entries (wins over push/pop)
//   din       - entry to write
//   dout      - head entry (meaningful only when count != 0)
//   count     - number of valid entries, 0..2
module fetch_fifo2
  import instr_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  // Guard against overflow/underflow; a full buffer still accepts a push
  // when the head leaves in the same cycle.
  assign do_pop  = pop & (count_q != 2'd0);
  assign do_push = push & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch with 2-deep prefetch buffer and redirect handling
//
// Purpose: issues word fetches to instruction memory, buffers responses in a
// two-entry FIFO and presents the head to the F/D pipeline register. Taken
// branches/jumps from Execute flush the buffer and restart fetch at the target.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   StallF      - downstream does not accept the head entry this cycle
//   PCSrcE      - redirect request from Execute
//   PCTargetE   - redirect target (low two bits ignored)
//   ImemReq     - memory request, held until ImemAck
//   ImemAddr    - request address, stable while ImemReq=1
//   ImemAck     - memory response valid
//   ImemRdata   - instruction word, valid with ImemAck
//   InstrF      - head instruction (0 when no valid head)
//   PCF         - head instruction address (0 when no valid head)
//   PCPlus4F    - PCF + 4
//   FetchValid  - head entry valid; 0 is a bubble
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemAck,
  input  logic [XLEN-1:0] ImemRdata,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            FetchValid
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_addr_q;

  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic [1:0]      count;
  logic            consume;
  logic            push;
  logic            pop;
  logic [1:0]      count_after_pop;
  logic [1:0]      count_after_push;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_req_addr;

  assign target        = align_word(PCTargetE);
  assign next_req_addr = req_addr_q + 32'd4;

  assign FetchValid = (count != 2'd0);
  assign consume    = FetchValid & ~StallF;

  // A redirect squashes everything: no pop, no push, buffer flushed.
  assign pop  = consume & ~PCSrcE;
  assign push = (state_q == REQ) & ImemAck & ~PCSrcE;

  assign count_after_pop  = count - {1'b0, pop};
  assign count_after_push = count_after_pop + {1'b0, push};

  assign push_entry.instr = ImemRdata;
  assign push_entry.pc    = req_addr_q;

  fetch_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (PCSrcE),
    .din   (push_entry),
    .dout  (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (PCSrcE) begin
            state_q    <= REQ;
            pc_q       <= target;
            req_addr_q <= target;
          end else if (count_after_pop < 2'd2) begin
            state_q    <= REQ;
            req_addr_q <= pc_q;
          end
        end
        REQ: begin
          if (ImemAck) begin
            if (PCSrcE) begin
              pc_q       <= target;
              req_addr_q <= target;
            end else begin
              pc_q <= next_req_addr;
              // Keep issuing back-to-back only while there is room for the
              // response; otherwise wait in IDLE for the head to drain.
              if (count_after_push < 2'd2) begin
                req_addr_q <= next_req_addr;
              end else begin
                state_q <= IDLE;
              end
            end
          end else if (PCSrcE) begin
            // The bus request cannot be withdrawn; let it finish and drop it.
            state_q <= DROP;
            pc_q    <= target;
          end
        end
        DROP: begin
          if (PCSrcE) begin
            pc_q <= target;
          end
          if (ImemAck) begin
            state_q    <= REQ;
            req_addr_q <= PCSrcE ? target : pc_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ImemReq  = (state_q != IDLE);
  assign ImemAddr = req_addr_q;

  assign InstrF   = FetchValid ? head.instr : '0;
  assign PCF      = FetchValid ? head.pc : '0;
  assign PCPlus4F = PCF + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        StallF, PCSrcE, ImemAck, ImemReq, FetchValid;
  logic [31:0] PCTargetE, ImemAddr, ImemRdata, InstrF, PCF, PCPlus4F;

  logic        StallF_w, PCSrcE_w, ImemAck_w, ImemReq_w, FetchValid_w;
  logic [31:0] PCTargetE_w, ImemAddr_w, ImemRdata_w, InstrF_w, PCF_w, PCPlus4F_w;

  int n_pass  = 0;
  int n_total = 0;
  int lat     = 1;
  int wait_cnt = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemRdata(ImemRdata),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .FetchValid(FetchValid)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .StallF(StallF_w), .PCSrcE(PCSrcE_w), .PCTargetE(PCTargetE_w),
    .ImemReq(ImemReq_w), .ImemAddr(ImemAddr_w), .ImemAck(ImemAck_w), .ImemRdata(ImemRdata_w),
    .InstrF(InstrF_w), .PCF(PCF_w), .PCPlus4F(PCPlus4F_w), .FetchValid(FetchValid_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one clock and let both memory models answer. The main memory
  // acks after 'lat' cycles of a held request; the wrap instance is zero-wait.
  task automatic step();
    logic prev_req;
    logic prev_ack;
    prev_req = ImemReq;
    prev_ack = ImemAck;
    @(posedge clk);
    #1;
    if (ImemReq && prev_req && !prev_ack) wait_cnt++;
    else wait_cnt = 0;
    ImemAck     = ImemReq && (wait_cnt >= lat - 1);
    ImemRdata   = ImemAck ? mem_word(ImemAddr) : 32'hDEAD_BEEF;
    ImemAck_w   = ImemReq_w;
    ImemRdata_w = mem_word(ImemAddr_w);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    ImemAck = 1'b0; ImemRdata = '0;
    ImemAck_w = 1'b0; ImemRdata_w = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ImemReq",    {31'b0, ImemReq},    32'd0);
    chk("rst FetchValid", {31'b0, FetchValid}, 32'd0);
    chk("rst InstrF",     InstrF,              32'd0);
    chk("rst PCF",        PCF,                 32'd0);
    chk("rst PCPlus4F",   PCPlus4F,            32'd4);
    chk("rst_w PCPlus4F", PCPlus4F_w,          32'd4);
    rst = 1'b0;
    wait_cnt = 0;
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_fv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[19];

  initial begin
    rst = 1'b1;
    StallF_w = 1'b0; PCSrcE_w = 1'b0; PCTargetE_w = '0;

    // Zero-wait memory, RESET_PC=0. Row i: outputs expected in cycle i after
    // reset release; inputs are applied in that same cycle.
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC};
    vecs[11] = '{1'b0, 1'b1, 32'h203, 1'b1, 32'h14,  1'b1, 32'h10};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
    vecs[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204};
    vecs[15] = '{1'b1, 1'b1, 32'h40,  1'b0, 32'h0,   1'b1, 32'h204};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  1'b1, 32'h40};
    vecs[18] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h48,  1'b1, 32'h44};

    lat = 1;
    apply_reset();
    for (int i = 0; i < 19; i++) begin
      if (i > 0) step();
      StallF    = vecs[i].stall;
      PCSrcE    = vecs[i].redir;
      PCTargetE = vecs[i].tgt;
      chk($sformatf("row%0d ImemReq", i), {31'b0, ImemReq}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        chk($sformatf("row%0d ImemAddr", i), ImemAddr, vecs[i].exp_addr);
      chk($sformatf("row%0d FetchValid", i), {31'b0, FetchValid}, {31'b0, vecs[i].exp_fv});
      chk($sformatf("row%0d PCF", i), PCF, vecs[i].exp_pc);
      chk($sformatf("row%0d InstrF", i), InstrF,
          vecs[i].exp_fv ? mem_word(vecs[i].exp_pc) : 32'h0);
      chk($sformatf("row%0d PCPlus4F", i), PCPlus4F, vecs[i].exp_pc + 32'd4);
    end
    StallF = 1'b0; PCSrcE = 1'b0;

    // Wrap-around fetch from RESET_PC=FFFF_FFF8 (second instance).
    apply_reset();
    step();
    chk("wrap req addr", ImemAddr_w, 32'hFFFF_FFF8);
    step();
    chk("wrap pc0",   PCF_w,      32'hFFFF_FFF8);
    chk("wrap pc0+4", PCPlus4F_w, 32'hFFFF_FFFC);
    step();
    chk("wrap pc1",   PCF_w,      32'hFFFF_FFFC);
    chk("wrap pc1+4", PCPlus4F_w, 32'h0000_0000);
    step();
    chk("wrap pc2",    PCF_w,      32'h0000_0000);
    chk("wrap instr2", InstrF_w,   mem_word(32'h0));
    chk("wrap fv2",    {31'b0, FetchValid_w}, 32'd1);

    // 3-cycle memory, redirect to 0x103 while the first fetch is waiting.
    lat = 3;
    apply_reset();
    step();
    chk("drop req0", {31'b0, ImemReq}, 32'd1);
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0103;
    step();
    PCSrcE = 1'b0; PCTargetE = '0;
    chk("drop held addr", ImemAddr, 32'h0);
    chk("drop held req",  {31'b0, ImemReq}, 32'd1);
    chk("drop fv a",      {31'b0, FetchValid}, 32'd0);
    step();
    chk("drop fv b",      {31'b0, FetchValid}, 32'd0);
    step();
    chk("drop new addr",  ImemAddr, 32'h0000_0100);
    chk("drop fv c",      {31'b0, FetchValid}, 32'd0);
    step();
    step();
    chk("drop fv d",      {31'b0, FetchValid}, 32'd0);
    step();
    chk("drop fv e",      {31'b0, FetchValid}, 32'd1);
    chk("drop pc",        PCF, 32'h0000_0100);
    chk("drop instr",     InstrF, mem_word(32'h0000_0100));

    // Reset while a request is outstanding, then a stray late ack.
    lat = 1;
    apply_reset();
    repeat (4) step();
    lat = 100;
    step();
    chk("pre-rst req",  {31'b0, ImemReq}, 32'd1);
    chk("pre-rst addr", ImemAddr, 32'h10);
    apply_reset();
    ImemAck = 1'b1; ImemRdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    chk("late ack fv",   {31'b0, FetchValid}, 32'd0);
    chk("late ack req",  {31'b0, ImemReq}, 32'd1);
    chk("late ack addr", ImemAddr, 32'h0);
    ImemAck = 1'b0;
    lat = 1;
    step();
    step();
    chk("post-rst fv",    {31'b0, FetchValid}, 32'd1);
    chk("post-rst pc",    PCF, 32'h0);
    chk("post-rst instr", InstrF, mem_word(32'h0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
